dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a 512x32 synchronous data RAM: the CPU MEM stage and a debug/dump port share
// one RAM through an IDLE/ISSUE/WAIT sequencer with CPU priority bounded by an age counter.
module dmem_arbiter #(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [8:0]  c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [8:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic        own_q, own_d;  // 1: debug port owns the current access
  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        c_ack_q, c_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [2:0]  age_q, age_d;

  logic busy, arb, c_elig, d_elig, age_hit, c_win, d_win;

  always_comb begin
    busy    = (state_q == StIssue) || (state_q == StWait);
    arb     = (state_q == StIdle) || (state_q == StWait);
    c_elig  = c_req && !(busy && !own_q) && !c_ack_q;
    d_elig  = d_req && !(busy && own_q) && !d_ack_q;
    age_hit = {29'd0, age_q} >= AGE_LIMIT;
    d_win   = arb && d_elig && (!c_elig || age_hit);
    c_win   = arb && c_elig && !d_win;
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    age_d     = age_q;

    // Completion of the owner's access on the edge leaving WAIT.
    if (state_q == StWait) begin
      if (own_q) begin
        d_ack_d = 1'b1;
        if (!we_q) d_rdata_d = m_rdata;
      end else begin
        c_ack_d = 1'b1;
        if (!we_q) c_rdata_d = m_rdata;
      end
    end

    if (c_win) begin
      state_d = StIssue;
      own_d   = 1'b0;
      we_d    = c_we;
      addr_d  = c_addr;
      wdata_d = c_wdata;
    end else if (d_win) begin
      state_d = StIssue;
      own_d   = 1'b1;
      we_d    = d_we;
      addr_d  = d_addr;
      wdata_d = d_wdata;
    end else if (state_q == StIssue) begin
      state_d = StWait;
    end else begin
      state_d = StIdle;
    end

    if (!d_req || d_win) begin
      age_d = '0;
    end else if (c_win && d_elig && (age_q != 3'd7)) begin
      age_d = age_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      own_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      age_q     <= age_d;
    end
  end

  assign m_en    = (state_q == StIssue);
  assign m_we    = m_en && we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign c_ack   = c_ack_q;
  assign d_ack   = d_ack_q;
  assign c_stall = c_req && !c_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural 512x32 RAM, per-port drivers that push expected
// read data to scoreboard queues, and one task per scenario popping and comparing on each ack.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [8:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic [31:0] c_rdata;
  logic        c_ack, c_stall;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [8:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en, m_we;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;

  dmem_arbiter #(.AGE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [512];
  logic [31:0] shadow [512];
  int          issue_cyc [512];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] c_rd_model = '0;
  logic [31:0] d_rd_model = '0;
  logic [31:0] c_exp_q [$];
  logic [31:0] d_exp_q [$];

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
      issue_cyc[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_en === 1'b1) begin
      if (m_we) ram[m_addr] <= m_wdata;
      m_rdata <= ram[m_addr];
    end
  end

  always @(negedge clk) if (m_en === 1'b1) issue_cyc[m_addr] = cyc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the edge that ends the ack cycle.
  task automatic c_do(input logic we, input logic [8:0] a, input logic [31:0] wd,
                      output int st, output int ak, output logic [31:0] rd,
                      output logic got, output logic sok);
    if (!we) c_rd_model = shadow[a];
    c_exp_q.push_back(c_rd_model);
    if (we) shadow[a] = wd;
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
    st = cyc; ak = 0; rd = '0; got = 1'b0; sok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (c_ack === 1'b1) begin
        got = 1'b1; ak = cyc; rd = c_rdata;
        if (c_stall !== 1'b0) sok = 1'b0;
        break;
      end
      if (c_stall !== 1'b1) sok = 1'b0;
    end
    @(posedge clk); #1;
    c_req = 1'b0;
  endtask

  task automatic d_do(input logic we, input logic [8:0] a, input logic [31:0] wd,
                      output int st, output int ak, output logic [31:0] rd, output logic got);
    if (!we) d_rd_model = shadow[a];
    d_exp_q.push_back(d_rd_model);
    if (we) shadow[a] = wd;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    st = cyc; ak = 0; rd = '0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin
        got = 1'b1; ak = cyc; rd = d_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_en, m_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_men_mwe: got %b want 00", {m_en, m_we});
    end
    n_cmp++;
    if ({m_addr, m_wdata} !== 41'd0) begin
      n_fail++; $display("FAIL reset_maddr_mwdata: got %h/%h want 0/0", m_addr, m_wdata);
    end
    n_cmp++;
    if ({c_ack, d_ack, c_stall} !== 3'b000) begin
      n_fail++; $display("FAIL reset_acks_stall: got %b want 000", {c_ack, d_ack, c_stall});
    end
    n_cmp++;
    if ({c_rdata, d_rdata} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", c_rdata, d_rdata);
    end
    c_req = 1'b1; c_addr = 9'd3;
    @(posedge clk); #1;
    n_cmp++;
    if ({m_en, c_stall} !== 2'b01) begin
      n_fail++; $display("FAIL reset_hold_req: got m_en,c_stall=%b want 01", {m_en, c_stall});
    end
    c_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int st, ak; logic [31:0] rd, exp; logic got, sok;
    c_do(1'b1, 9'd5, 32'hDEADBEEF, st, ak, rd, got, sok);
    exp = c_exp_q.pop_front();
    n_cmp++;
    if (!got || (ak - st) != 3) begin
      n_fail++; $display("FAIL wr_latency: got %0d (ack %b) want 3", ak - st, got);
    end
    n_cmp++;
    if (!sok) begin n_fail++; $display("FAIL wr_stall: got bad stall want stall until ack"); end
    n_cmp++;
    if (rd !== exp) begin n_fail++; $display("FAIL wr_rdata: got %h want %h", rd, exp); end
    c_do(1'b0, 9'd5, 32'h0, st, ak, rd, got, sok);
    exp = c_exp_q.pop_front();
    n_cmp++;
    if (!got || (ak - st) != 3) begin
      n_fail++; $display("FAIL rd_latency: got %0d (ack %b) want 3", ak - st, got);
    end
    n_cmp++;
    if (!sok) begin n_fail++; $display("FAIL rd_stall: got bad stall want stall until ack"); end
    n_cmp++;
    if (rd !== exp) begin n_fail++; $display("FAIL rd_deadbeef: got %h want %h", rd, exp); end
    c_do(1'b1, 9'd6, 32'h00000011, st, ak, rd, got, sok);
    exp = c_exp_q.pop_front();
    n_cmp++;
    if (rd !== exp) begin n_fail++; $display("FAIL wr_keeps_rdata: got %h want %h", rd, exp); end
  endtask

  task automatic test_contention();
    int cst, cak, dst, dak; logic [31:0] crd, drd, exp; logic cgot, dgot, sok;
    c_do(1'b1, 9'd1, 32'h0000A1A1, cst, cak, crd, cgot, sok);
    exp = c_exp_q.pop_front();
    c_do(1'b1, 9'd2, 32'h0000B2B2, cst, cak, crd, cgot, sok);
    exp = c_exp_q.pop_front();
    fork
      c_do(1'b0, 9'd1, 32'h0, cst, cak, crd, cgot, sok);
      d_do(1'b0, 9'd2, 32'h0, dst, dak, drd, dgot);
    join
    n_cmp++;
    if (!cgot || (cak - cst) != 3) begin
      n_fail++; $display("FAIL cont_c_first: got latency %0d (ack %b) want 3", cak - cst, cgot);
    end
    n_cmp++;
    if (!dgot || (dak - cak) != 2) begin
      n_fail++; $display("FAIL cont_ack_gap: got %0d (ack %b) want 2", dak - cak, dgot);
    end
    n_cmp++;
    if (issue_cyc[2] != cak) begin
      n_fail++; $display("FAIL cont_d_issue: got cycle %0d want %0d", issue_cyc[2], cak);
    end
    exp = c_exp_q.pop_front();
    n_cmp++;
    if (crd !== exp) begin n_fail++; $display("FAIL cont_c_rdata: got %h want %h", crd, exp); end
    exp = d_exp_q.pop_front();
    n_cmp++;
    if (drd !== exp) begin n_fail++; $display("FAIL cont_d_rdata: got %h want %h", drd, exp); end
  endtask

  task automatic test_fairness();
    int st, ak, dst, dak, nb; logic [31:0] rd, drd, exp; logic got, dgot, sok;
    int cak_a [6]; logic [31:0] crd_a [6]; logic cgot_a [6];
    c_do(1'b1, 9'd100, 32'h0D0D0100, st, ak, rd, got, sok);
    exp = c_exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      c_do(1'b1, 9'(200 + i), 32'hC0 + 32'(i), st, ak, rd, got, sok);
      exp = c_exp_q.pop_front();
    end
    fork
      d_do(1'b0, 9'd100, 32'h0, dst, dak, drd, dgot);
      for (int i = 0; i < 6; i++) begin
        c_do(1'b0, 9'(200 + i), 32'h0, st, cak_a[i], crd_a[i], cgot_a[i], sok);
      end
    join
    nb = 0;
    for (int i = 0; i < 6; i++) if (cgot_a[i] && (cak_a[i] - 2) < issue_cyc[100]) nb++;
    n_cmp++;
    if (!dgot || nb < 1 || nb > 4) begin
      n_fail++; $display("FAIL fair_c_grants_before_d: got %0d (d ack %b) want 1..4", nb, dgot);
    end
    exp = d_exp_q.pop_front();
    n_cmp++;
    if (drd !== exp) begin n_fail++; $display("FAIL fair_d_rdata: got %h want %h", drd, exp); end
    for (int i = 0; i < 6; i++) begin
      exp = c_exp_q.pop_front();
      n_cmp++;
      if (!cgot_a[i] || crd_a[i] !== exp) begin
        n_fail++; $display("FAIL fair_c_rdata[%0d]: got %h want %h", i, crd_a[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st, ak; logic [31:0] rd, exp; logic got, sok, ack_seen;
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'd7; c_wdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    n_cmp++;
    if (m_en !== 1'b1 || m_addr !== 9'd7) begin
      n_fail++; $display("FAIL rmid_issue: got m_en %b addr %0d want 1/7", m_en, m_addr);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_en, m_we} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_men_drop: got %b want 00", {m_en, m_we});
    end
    c_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (c_ack !== 1'b0) ack_seen = 1'b1; end
    @(posedge clk); #1;
    rst = 1'b1;
    c_rd_model = '0; d_rd_model = '0;
    repeat (3) begin @(negedge clk); if (c_ack !== 1'b0) ack_seen = 1'b1; end
    n_cmp++;
    if (ack_seen) begin n_fail++; $display("FAIL rmid_no_ack: got ack 1 want 0"); end
    @(posedge clk); #1;
    rst = 1'b0;
    #2 rst = 1'b1;
    c_do(1'b0, 9'd7, 32'h0, st, ak, rd, got, sok);
    exp = c_exp_q.pop_front();
    n_cmp++;
    if (!got || (ak - st) != 3) begin
      n_fail++; $display("FAIL rmid_first_arb: got latency %0d (ack %b) want 3", ak - st, got);
    end
    n_cmp++;
    if (rd !== exp) begin n_fail++; $display("FAIL rmid_addr7: got %h want %h", rd, exp); end
  endtask

  task automatic test_sweep();
    int st, ak; logic [31:0] rd, exp; logic got, sok, lat_ok;
    lat_ok = 1'b1;
    for (int a = 0; a < 512; a++) begin
      c_do(1'b1, 9'(a), 32'(a), st, ak, rd, got, sok);
      exp = c_exp_q.pop_front();
      if (!got || (ak - st) != 3) lat_ok = 1'b0;
    end
    for (int a = 0; a < 512; a++) begin
      d_do(1'b0, 9'(a), 32'h0, st, ak, rd, got);
      exp = d_exp_q.pop_front();
      if (!got || (ak - st) != 3) lat_ok = 1'b0;
      n_cmp++;
      if (!got || rd !== exp) begin
        n_fail++; $display("FAIL sweep_d_rdata[%0d]: got %h want %h", a, rd, exp);
      end
    end
    n_cmp++;
    if (!lat_ok) begin n_fail++; $display("FAIL sweep_latency: got non-3 latency want 3"); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
